// File: rtl/rep_pol_ctr.sv
// Per-set, per-way usage counters feeding the replacement-policy comparator.
// Counts hits/fills, serves registered lookups with write bypass, and runs a set-by-set flush sweep.
module rep_pol_ctr #(
  parameter int NUM_SETS = 16,
  parameter int SET_W    = $clog2(NUM_SETS),
  parameter int CTR_W    = 32,
  parameter int FILL_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_valid,
  input  logic [SET_W-1:0] acc_set,
  input  logic [1:0]       acc_way,
  input  logic             acc_fill,
  input  logic             lkp_valid,
  input  logic [SET_W-1:0] lkp_set,
  input  logic             flush,
  output logic [31:0]      line_0,
  output logic [31:0]      line_1,
  output logic [31:0]      line_2,
  output logic [31:0]      line_3,
  output logic             out_valid,
  output logic             busy,
  output logic [0:0]       dbg_state
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [CTR_W-1:0] MAX     = '1;
  localparam logic [CTR_W-1:0] AGE_VAL = (MAX >> 1) + 1'b1;
  localparam logic [CTR_W-1:0] FILL_V  = CTR_W'(FILL_VAL);

  logic [0:0]             r_state;
  logic [SET_W-1:0]       r_idx;
  logic [3:0][CTR_W-1:0]  r_ctr [NUM_SETS];

  logic [3:0][CTR_W-1:0]  w_cur_row;
  logic [3:0][CTR_W-1:0]  w_new_row;
  logic [3:0][CTR_W-1:0]  w_lkp_row;
  logic                   w_accept;
  logic                   w_acc_en;
  logic                   w_lkp_en;

  // Next value of the accessed set's row: fill load, saturating-free increment, or aging halve.
  always_comb begin
    w_cur_row = r_ctr[acc_set];
    w_new_row = w_cur_row;
    if (acc_fill) begin
      w_new_row[acc_way] = FILL_V;
    end else if (w_cur_row[acc_way] == MAX) begin
      for (int k = 0; k < 4; k++) begin
        w_new_row[k] = w_cur_row[k] >> 1;
      end
      w_new_row[acc_way] = AGE_VAL;
    end else begin
      w_new_row[acc_way] = w_cur_row[acc_way] + 1'b1;
    end
  end

  // A flush request in IDLE wins over any same-cycle access or lookup.
  assign w_accept  = (r_state == ST_IDLE) && !flush;
  assign w_acc_en  = w_accept && acc_valid;
  assign w_lkp_en  = w_accept && lkp_valid;
  assign w_lkp_row = (w_acc_en && (acc_set == lkp_set)) ? w_new_row : r_ctr[lkp_set];

  assign busy      = (r_state == ST_FLUSH);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      out_valid <= 1'b0;
      line_0    <= '0;
      line_1    <= '0;
      line_2    <= '0;
      line_3    <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        r_ctr[s] <= '0;
      end
    end else begin
      out_valid <= w_lkp_en;
      if (w_lkp_en) begin
        line_0 <= 32'(w_lkp_row[0]);
        line_1 <= 32'(w_lkp_row[1]);
        line_2 <= 32'(w_lkp_row[2]);
        line_3 <= 32'(w_lkp_row[3]);
      end
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_state <= ST_FLUSH;
            r_idx   <= '0;
          end else if (w_acc_en) begin
            r_ctr[acc_set] <= w_new_row;
          end
        end
        default: begin
          r_ctr[r_idx] <= '0;
          r_idx        <= r_idx + 1'b1;
          if (r_idx == SET_W'(NUM_SETS - 1)) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep_pol_ctr.sv
// Bench for rep_pol_ctr (16 sets, 4-bit counters): vector table plus hand sequences
// for aging, flush and reset-during-flush, with lookup results checked from an expected queue.
module tb_rep_pol_ctr;

  localparam int NUM_SETS = 16;
  localparam int SET_W    = 4;
  localparam int CTR_W    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             acc_valid = 1'b0;
  logic [SET_W-1:0] acc_set = '0;
  logic [1:0]       acc_way = '0;
  logic             acc_fill = 1'b0;
  logic             lkp_valid = 1'b0;
  logic [SET_W-1:0] lkp_set = '0;
  logic             flush = 1'b0;
  logic [31:0]      line_0, line_1, line_2, line_3;
  logic             out_valid, busy;
  logic [0:0]       dbg_state;

  rep_pol_ctr #(.NUM_SETS(NUM_SETS), .SET_W(SET_W), .CTR_W(CTR_W), .FILL_VAL(1)) dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_set(acc_set), .acc_way(acc_way), .acc_fill(acc_fill),
    .lkp_valid(lkp_valid), .lkp_set(lkp_set), .flush(flush),
    .line_0(line_0), .line_1(line_1), .line_2(line_2), .line_3(line_3),
    .out_valid(out_valid), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [127:0] exp_q[$];

  typedef struct {
    logic       av;
    logic [3:0] as;
    logic [1:0] aw;
    logic       af;
    logic       lv;
    logic [3:0] ls;
    logic [3:0] e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic av, logic [3:0] as, logic [1:0] aw, logic af,
                              logic lv, logic [3:0] ls,
                              logic [3:0] e0, logic [3:0] e1, logic [3:0] e2, logic [3:0] e3);
    vec_t v;
    v.av = av; v.as = as; v.aw = aw; v.af = af; v.lv = lv; v.ls = ls;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  function automatic logic [127:0] pack4(logic [3:0] e0, logic [3:0] e1, logic [3:0] e2, logic [3:0] e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending lookup.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected out_valid", 128'd1, 128'd0);
      else chk("lookup", {line_3, line_2, line_1, line_0}, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    acc_valid = 1'b0; acc_fill = 1'b0; lkp_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic hit_n(input logic [3:0] s, input logic [1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      acc_valid = 1'b1; acc_set = s; acc_way = w; acc_fill = 1'b0;
      step();
    end
    idle_inputs();
  endtask

  // Optional same-cycle access alongside a lookup with its expected row.
  task automatic lookup(input logic [3:0] s, input logic [127:0] exp);
    lkp_valid = 1'b1; lkp_set = s;
    exp_q.push_back(exp);
    step();
    idle_inputs();
  endtask

  task automatic drain();
    repeat (2) step();
    chk("queue drained", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic sweep_zero();
    for (int s = 0; s < NUM_SETS; s++) lookup(4'(s), 128'd0);
  endtask

  int cnt;

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    vecs[1]  = mk(1, 5, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 5, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 5, 2, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 1, 5, 1, 0, 3, 0);
    vecs[6]  = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 7, 1, 0, 1, 7, 0, 5, 0, 0);
    vecs[11] = mk(1, 7, 1, 0, 1, 6, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 7, 0, 6, 0, 0);

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("reset lines", {line_3, line_2, line_1, line_0}, 128'd0);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);

    foreach (vecs[i]) begin
      acc_valid = vecs[i].av; acc_set = vecs[i].as; acc_way = vecs[i].aw; acc_fill = vecs[i].af;
      lkp_valid = vecs[i].lv; lkp_set = vecs[i].ls;
      if (vecs[i].lv) exp_q.push_back(pack4(vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3));
      step();
    end
    idle_inputs();
    drain();

    // Aging on set 2: build 15,8,3,0 then hit the saturated way with a bypassed lookup.
    hit_n(2, 0, 15);
    hit_n(2, 1, 8);
    hit_n(2, 2, 3);
    lookup(2, pack4(15, 8, 3, 0));
    acc_valid = 1'b1; acc_set = 2; acc_way = 0; acc_fill = 1'b0;
    lookup(2, pack4(8, 4, 1, 0));
    lookup(2, pack4(8, 4, 1, 0));
    hit_n(2, 2, 2);
    acc_valid = 1'b1; acc_set = 2; acc_way = 2; acc_fill = 1'b0;
    lookup(2, pack4(8, 4, 4, 0));
    hit_n(2, 0, 7);
    acc_valid = 1'b1; acc_set = 2; acc_way = 0; acc_fill = 1'b1;
    lookup(2, pack4(1, 4, 4, 0));
    drain();

    // Flush with same-cycle access and lookup; both must be dropped.
    flush = 1'b1; acc_valid = 1'b1; acc_set = 9; acc_way = 0; acc_fill = 1'b0;
    lkp_valid = 1'b1; lkp_set = 5;
    step();
    chk("busy after flush", 128'(busy), 128'd1);
    lkp_set = 9;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      step();
    end
    idle_inputs();
    chk("busy cycles", 128'(cnt), 128'd16);
    chk("lines held during flush", {line_3, line_2, line_1, line_0}, pack4(1, 4, 4, 0));
    sweep_zero();
    drain();

    // Reset in the middle of a sweep.
    hit_n(12, 1, 3);
    flush = 1'b1;
    step();
    idle_inputs();
    repeat (6) step();
    chk("busy mid-flush", 128'(busy), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("busy after rst", 128'(busy), 128'd0);
    chk("state after rst", 128'(dbg_state), 128'd0);
    chk("lines after rst", {line_3, line_2, line_1, line_0}, 128'd0);
    sweep_zero();
    acc_valid = 1'b1; acc_set = 1; acc_way = 3; acc_fill = 1'b0;
    step();
    idle_inputs();
    lookup(1, pack4(0, 0, 0, 1));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rep_pol_ctr.md
# rep_pol_ctr

Per-set, per-way usage-counter store for the 4-way set-associative cache. It sits directly upstream of the combinational replacement-policy comparator: it counts hits and fills per way, and on a lookup presents the four counters of the requested set as line_0..line_3. The comparator then selects the least-used way as the victim. The block also provides a multi-cycle flush that clears all counters set by set.

## Interface
- NUM_SETS, 16, number of cache sets (power of two, ≥2)
- SET_W, $clog2(NUM_SETS), set index width
- CTR_W, 32, counter width (1..32); outputs are zero-extended to 32 bits
- FILL_VAL, 1, counter value loaded into a way on a fill (must be < 2^CTR_W)

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset; synchronous and active-high
- acc_valid  in  1  access event this cycle
- acc_set  in  SET_W  set of the access
- acc_way  in  2  way of the access
- acc_fill  in  1  1 = fill (line replaced), 0 = hit
- lkp_valid  in  1  lookup request
- lkp_set  in  SET_W  set to read
- flush  in  1  single-cycle request to clear all counters
- line_0..line_3  out  32 each  counters of ways 0..3 of the looked-up set, zero-extended
- out_valid  out  1  line_* are valid for the lookup issued in the previous cycle
- busy  out  1  flush sweep in progress

## Operation
- Storage: NUM_SETS×4 counters of CTR_W bits. MAX = 2^CTR_W−1.
- FSM has two states, IDLE and FLUSH.
  - IDLE: accepts accesses, lookups and flush.
  - IDLE → FLUSH: taken when flush=1. The sweep index starts at 0.
  - FLUSH: each cycle, all 4 counters of set[index] are cleared to 0 and the index increments.
  - FLUSH → IDLE: taken after set NUM_SETS−1 is cleared. FLUSH therefore lasts exactly NUM_SETS cycles.
- Hit (acc_valid=1, acc_fill=0) in IDLE:
  - If the counter is < MAX, it increments by 1.
  - If the counter == MAX (aging), all 4 counters of that set shift right by 1. The hit way then becomes (MAX>>1)+1. The other ways keep their halved value.
- Fill (acc_valid=1, acc_fill=1) in IDLE: the way is loaded with FILL_VAL. Other ways are unchanged. A fill never triggers aging.
- Lookup (lkp_valid=1) in IDLE: line_k is registered from the counter of way k in lkp_set, and out_valid=1 on the next cycle.
- Same-cycle access and lookup to the same set: the lookup returns the post-update values. The write is bypassed, including the aging case.
- Same-cycle access and lookup to different sets: both are performed independently.
- flush=1 in IDLE together with acc_valid and/or lkp_valid: the flush wins. The access is dropped and the lookup is dropped, so out_valid=0 next cycle.
- While busy=1:
  - acc_valid, lkp_valid and flush are ignored.
  - out_valid stays 0.
  - line_* hold their last values.
- Tie behaviour (equal counters) is resolved downstream. This block never reorders ways.

## Timing
- Reset values:
  - all counters 0
  - line_0..line_3 = 0
  - out_valid = 0
  - busy = 0
  - state IDLE, sweep index 0
- rst asserted mid-flush: the cycle after rst, the block is in IDLE with busy=0 and all counters 0.
- rst has priority over every other input.
- Access update latency: 1 cycle. A lookup issued in the cycle after the access sees the new value; a lookup issued in the same cycle sees it via the bypass.
- Lookup latency: 1 cycle, fully pipelined. One lookup per cycle is accepted. out_valid is a single-cycle pulse per lookup.
- Flush:
  - busy rises the cycle after flush is sampled and stays high exactly NUM_SETS cycles.
  - The first accepted request is in the cycle busy returns to 0.
- Counter arithmetic is CTR_W-bit unsigned and never wraps. The upper 32−CTR_W bits of line_* are always 0.

## Test plan
- Reset then lookup: rst 1 cycle; lookup set 3 → next cycle out_valid=1, line_0..3 = 0,0,0,0.
- Hits and fill: 3 hits on set 5 way 2, then a fill on set 5 way 0, then lookup set 5 → line_0=1, line_1=0, line_2=3, line_3=0.
- Bypass: hit on set 7 way 1 and lookup set 7 in the same cycle (prior count 4) → line_1=5 next cycle. Repeat with a lookup of set 6 in the same cycle → set 6 unchanged and set 7 updated on a later lookup.
- Aging (CTR_W=4): set 2 ways = 15,8,3,0; hit way 0 → lookup gives 8,4,1,0. Hit way 2 at 3 → 4, no aging.
- Flush (NUM_SETS=16): flush with acc_valid in the same cycle → access dropped. busy=1 for exactly 16 cycles, and lookups during busy give no out_valid. Afterwards every set reads 0,0,0,0.
- Reset mid-flush: rst at sweep index 6 → busy=0 the next cycle and all sets read 0. A hit on set 1 way 3 then reads back as 1.
